// File: rtl/eth_tx_frame_arbiter.sv
// Purpose: shares one 8-bit MAC TX stream between a priority source (s0) and a bulk source (s1), arbitrating per frame.
// Latency: 1 cycle from request to first beat (registered arbitration), then 0-cycle data passthrough.
// Backpressure: tx_axis_tready passes straight to the owning source; the other source, IDLE and GAP cycles see tready=0.
module eth_tx_frame_arbiter #(
    parameter int MAX_CONSEC    = 4,
    parameter int IFG_CYCLES    = 12,
    parameter int MAX_FRAME_LEN = 1514
) (
    input  logic        gtx_clk_bufg,
    input  logic        gtx_reset,
    input  logic [7:0]  s0_axis_tdata,
    input  logic        s0_axis_tvalid,
    input  logic        s0_axis_tlast,
    output logic        s0_axis_tready,
    input  logic [7:0]  s1_axis_tdata,
    input  logic        s1_axis_tvalid,
    input  logic        s1_axis_tlast,
    output logic        s1_axis_tready,
    output logic [7:0]  tx_axis_tdata,
    output logic        tx_axis_tvalid,
    output logic        tx_axis_tlast,
    input  logic        tx_axis_tready,
    output logic [1:0]  grant,
    output logic        trunc_err,
    output logic [15:0] frame_cnt0,
    output logic [15:0] frame_cnt1
);

    typedef enum logic [2:0] {ST_IDLE, ST_GNT0, ST_GNT1, ST_DRAIN, ST_GAP} state_t;

    localparam logic [7:0]  LP_MAX_CONSEC = 8'(MAX_CONSEC);
    localparam logic [15:0] LP_LAST_BEAT  = 16'(MAX_FRAME_LEN - 1);
    // The IDLE arbitration cycle is itself one idle cycle on the wire, so GAP
    // only needs to cover IFG_CYCLES-1 cycles; with IFG_CYCLES<=1 GAP is skipped.
    localparam bit          LP_USE_GAP    = (IFG_CYCLES > 1);
    localparam logic [7:0]  LP_GAP_LOAD   = LP_USE_GAP ? 8'(IFG_CYCLES - 1) : 8'd0;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_grant;
    logic [7:0]  r_consec;
    logic [15:0] r_beat_cnt;
    logic [7:0]  r_gap_cnt;
    logic [15:0] r_frame_cnt0;
    logic [15:0] r_frame_cnt1;
    logic        r_trunc_err;

    logic   w_sel1;
    logic   w_src_vld;
    logic   w_src_last;
    logic   w_force_last;
    logic   w_in_gnt;
    logic   w_tx_hs;
    logic   w_eof;
    logic   w_eof_nat;
    logic   w_trunc;
    logic   w_drain_done;
    logic   w_frame_over;
    logic   w_take0;
    state_t w_done_state;

    // Owner is taken from the registered grant so it stays fixed through GNT and DRAIN.
    assign w_sel1       = r_grant[1];
    assign w_src_vld    = w_sel1 ? s1_axis_tvalid : s0_axis_tvalid;
    assign w_src_last   = w_sel1 ? s1_axis_tlast  : s0_axis_tlast;
    assign w_force_last = (r_beat_cnt == LP_LAST_BEAT);
    assign w_in_gnt     = (r_state == ST_GNT0) || (r_state == ST_GNT1);
    assign w_tx_hs      = w_in_gnt && w_src_vld && tx_axis_tready;
    assign w_eof        = w_tx_hs && (w_src_last || w_force_last);
    assign w_eof_nat    = w_tx_hs && w_src_last;
    assign w_trunc      = w_tx_hs && w_force_last && !w_src_last;
    assign w_drain_done = (r_state == ST_DRAIN) && w_src_vld && w_src_last;
    assign w_frame_over = w_eof_nat || w_drain_done;
    assign w_take0      = s0_axis_tvalid && (!s1_axis_tvalid || (r_consec < LP_MAX_CONSEC));
    assign w_done_state = LP_USE_GAP ? ST_GAP : ST_IDLE;

    // State register.
    always_ff @(posedge gtx_clk_bufg) begin
        if (gtx_reset) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next-state: arbitrate in IDLE, finish or truncate in GNT, discard in DRAIN, count out GAP.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take0)             w_state_nxt = ST_GNT0;
                else if (s1_axis_tvalid) w_state_nxt = ST_GNT1;
            end
            ST_GNT0, ST_GNT1: begin
                if (w_eof_nat)    w_state_nxt = w_done_state;
                else if (w_trunc) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_drain_done) w_state_nxt = w_done_state;
            end
            ST_GAP: begin
                if (r_gap_cnt <= 8'd1) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: passthrough of the owner in GNT, sink-only in DRAIN, everything quiet while in reset.
    always_comb begin
        tx_axis_tdata  = 8'd0;
        tx_axis_tvalid = 1'b0;
        tx_axis_tlast  = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (r_state)
            ST_GNT0: begin
                tx_axis_tdata  = s0_axis_tdata;
                tx_axis_tvalid = s0_axis_tvalid;
                tx_axis_tlast  = s0_axis_tlast | w_force_last;
                s0_axis_tready = tx_axis_tready;
            end
            ST_GNT1: begin
                tx_axis_tdata  = s1_axis_tdata;
                tx_axis_tvalid = s1_axis_tvalid;
                tx_axis_tlast  = s1_axis_tlast | w_force_last;
                s1_axis_tready = tx_axis_tready;
            end
            ST_DRAIN: begin
                s0_axis_tready = !w_sel1;
                s1_axis_tready = w_sel1;
            end
            default: ;
        endcase
        if (gtx_reset) begin
            tx_axis_tvalid = 1'b0;
            tx_axis_tlast  = 1'b0;
            s0_axis_tready = 1'b0;
            s1_axis_tready = 1'b0;
        end
    end

    // Grant, starvation counter, beat/gap counters, frame counters and truncation pulse.
    always_ff @(posedge gtx_clk_bufg) begin
        if (gtx_reset) begin
            r_grant      <= 2'b00;
            r_consec     <= 8'd0;
            r_beat_cnt   <= 16'd0;
            r_gap_cnt    <= 8'd0;
            r_frame_cnt0 <= 16'd0;
            r_frame_cnt1 <= 16'd0;
            r_trunc_err  <= 1'b0;
        end else begin
            r_trunc_err <= w_trunc;

            if (r_state == ST_IDLE) begin
                if (w_take0) begin
                    r_grant <= 2'b01;
                    if (s1_axis_tvalid && (r_consec != 8'hFF)) r_consec <= r_consec + 8'd1;
                end else if (s1_axis_tvalid) begin
                    r_grant  <= 2'b10;
                    r_consec <= 8'd0;
                end
            end else if (w_frame_over) begin
                r_grant <= 2'b00;
            end

            if (w_eof)        r_beat_cnt <= 16'd0;
            else if (w_tx_hs) r_beat_cnt <= r_beat_cnt + 16'd1;

            if (w_eof) begin
                if (w_sel1) r_frame_cnt1 <= r_frame_cnt1 + 16'd1;
                else        r_frame_cnt0 <= r_frame_cnt0 + 16'd1;
            end

            if (w_frame_over)          r_gap_cnt <= LP_GAP_LOAD;
            else if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt - 8'd1;
        end
    end

    assign grant      = r_grant;
    assign trunc_err  = r_trunc_err;
    assign frame_cnt0 = r_frame_cnt0;
    assign frame_cnt1 = r_frame_cnt1;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Bench for eth_tx_frame_arbiter: instance A uses default parameters, instance B has MAX_FRAME_LEN=16.
// Both share source/tready stimulus; sel picks which instance the source drivers and the monitor follow.
// Source queues feed the AXI drivers; the monitor records every tx beat with its grant and cycle number.
module tb_eth_tx_frame_arbiter;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } sb_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic [1:0] g;
        int         cyc;
    } beat_t;

    typedef struct {
        logic       s0v;
        logic [7:0] s0d;
        logic       s0l;
        logic       s1v;
        logic       txr;
        logic [7:0] ed;
        logic       ev;
        logic       el;
        logic       er0;
        logic       er1;
        logic [1:0] eg;
    } vec_t;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic       rst;
    logic [7:0] s0_d, s1_d;
    logic       s0_v, s0_l, s1_v, s1_l, txr;

    logic       a_s0r, a_s1r, a_tv, a_tl, a_te;
    logic [7:0] a_td;
    logic [1:0] a_g;
    logic [15:0] a_fc0, a_fc1;
    logic       b_s0r, b_s1r, b_tv, b_tl, b_te;
    logic [7:0] b_td;
    logic [1:0] b_g;
    logic [15:0] b_fc0, b_fc1;

    eth_tx_frame_arbiter #(.MAX_CONSEC(4), .IFG_CYCLES(12), .MAX_FRAME_LEN(1514)) u_dut_a (
        .gtx_clk_bufg(clk), .gtx_reset(rst),
        .s0_axis_tdata(s0_d), .s0_axis_tvalid(s0_v), .s0_axis_tlast(s0_l), .s0_axis_tready(a_s0r),
        .s1_axis_tdata(s1_d), .s1_axis_tvalid(s1_v), .s1_axis_tlast(s1_l), .s1_axis_tready(a_s1r),
        .tx_axis_tdata(a_td), .tx_axis_tvalid(a_tv), .tx_axis_tlast(a_tl), .tx_axis_tready(txr),
        .grant(a_g), .trunc_err(a_te), .frame_cnt0(a_fc0), .frame_cnt1(a_fc1)
    );

    eth_tx_frame_arbiter #(.MAX_CONSEC(4), .IFG_CYCLES(12), .MAX_FRAME_LEN(16)) u_dut_b (
        .gtx_clk_bufg(clk), .gtx_reset(rst),
        .s0_axis_tdata(s0_d), .s0_axis_tvalid(s0_v), .s0_axis_tlast(s0_l), .s0_axis_tready(b_s0r),
        .s1_axis_tdata(s1_d), .s1_axis_tvalid(s1_v), .s1_axis_tlast(s1_l), .s1_axis_tready(b_s1r),
        .tx_axis_tdata(b_td), .tx_axis_tvalid(b_tv), .tx_axis_tlast(b_tl), .tx_axis_tready(txr),
        .grant(b_g), .trunc_err(b_te), .frame_cnt0(b_fc0), .frame_cnt1(b_fc1)
    );

    logic        sel;
    logic        m_s0r, m_s1r, m_tv, m_tl, m_te;
    logic [7:0]  m_td;
    logic [1:0]  m_g;
    assign m_s0r = sel ? b_s0r : a_s0r;
    assign m_s1r = sel ? b_s1r : a_s1r;
    assign m_tv  = sel ? b_tv  : a_tv;
    assign m_tl  = sel ? b_tl  : a_tl;
    assign m_te  = sel ? b_te  : a_te;
    assign m_td  = sel ? b_td  : a_td;
    assign m_g   = sel ? b_g   : a_g;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sb_t   q0[$], q1[$], e0[$], e1[$];
    beat_t outq[$];
    logic  man, en0, en1, tog;
    logic [3:0] pat = 4'b1001;
    int    trunc_cnt, trunc_cyc, drain_cyc, g01_cyc, s1r_seen, mirror_err, s1v_first;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        outq.delete(); e0.delete(); e1.delete();
        trunc_cnt = 0; trunc_cyc = -1; drain_cyc = 0; g01_cyc = 0;
        s1r_seen = 0; mirror_err = 0; s1v_first = -1;
    endtask

    task automatic push_frame(input int src, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            sb_t b;
            b.d = base + 8'(i);
            b.l = (i == n - 1);
            if (src == 0) begin q0.push_back(b); e0.push_back(b); end
            else          begin q1.push_back(b); e1.push_back(b); end
        end
    endtask

    function automatic int count_last();
        int n = 0;
        foreach (outq[i]) if (outq[i].l) n++;
        return n;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_last(input string nm, input int n, input int budget);
        int k = 0;
        while (count_last() < n && k < budget) begin wait_cyc(1); k++; end
        if (count_last() < n) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d frames expected %0d", nm, count_last(), n);
        end
    endtask

    // Compares each recorded beat against the expected stream of the source its grant names.
    task automatic chk_stream(input string nm);
        int bad = 0;
        foreach (outq[i]) begin
            if (outq[i].g == 2'b01 && e0.size() > 0) begin
                if (outq[i].d !== e0[0].d || outq[i].l !== e0[0].l) bad++;
                void'(e0.pop_front());
            end else if (outq[i].g == 2'b10 && e1.size() > 0) begin
                if (outq[i].d !== e1[0].d || outq[i].l !== e1[0].l) bad++;
                void'(e1.pop_front());
            end else bad++;
        end
        bad += e0.size() + e1.size();
        chk(nm, bad, 0);
    endtask

    // Source 0 driver: pop on handshake seen at negedge, present next beat just after posedge.
    initial forever begin
        logic hs;
        @(negedge clk); hs = s0_v && m_s0r;
        @(posedge clk); #1;
        if (!man) begin
            if (hs && q0.size() > 0) void'(q0.pop_front());
            if (en0 && q0.size() > 0) begin s0_v = 1'b1; s0_d = q0[0].d; s0_l = q0[0].l; end
            else begin s0_v = 1'b0; s0_l = 1'b0; end
        end
    end

    // Source 1 driver.
    initial forever begin
        logic hs;
        @(negedge clk); hs = s1_v && m_s1r;
        @(posedge clk); #1;
        if (!man) begin
            if (hs && q1.size() > 0) void'(q1.pop_front());
            if (en1 && q1.size() > 0) begin s1_v = 1'b1; s1_d = q1[0].d; s1_l = q1[0].l; end
            else begin s1_v = 1'b0; s1_l = 1'b0; end
        end
    end

    // MAC ready: constant 1, or the 1,0,0,1 pattern when tog is set.
    initial forever begin
        int k = 0;
        @(posedge clk); #1;
        if (!man) txr = tog ? pat[k % 4] : 1'b1;
        k = k + 1;
    end

    // Monitor on the falling edge.
    initial forever begin
        @(negedge clk);
        if (m_tv && txr) outq.push_back('{m_td, m_tl, m_g, cyc});
        if (m_te) begin trunc_cnt++; trunc_cyc = cyc; end
        if ((m_g == 2'b10 && m_s1r && !m_tv) || (m_g == 2'b01 && m_s0r && !m_tv)) drain_cyc++;
        if (m_g == 2'b01) g01_cyc++;
        if (m_s1r) s1r_seen++;
        if (m_g == 2'b10 && m_s1r !== txr) mirror_err++;
        if (s1_v && s1v_first < 0) s1v_first = cyc;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   fsrc[$], ffirst[$], flast[$];
        int   exp_src[12];
        int   bad;
        logic newf;

        tbl[0] = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[1] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01};
        tbl[2] = '{1'b0, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01};
        tbl[3] = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
        tbl[4] = '{1'b1, 8'hA4, 1'b1, 1'b0, 1'b0, 8'hA4, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01};
        tbl[5] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01};
        tbl[6] = '{1'b0, 8'hA6, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        exp_src = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2, 1, 2};

        man = 1'b1; en0 = 1'b0; en1 = 1'b0; tog = 1'b0; sel = 1'b0;
        rst = 1'b1; txr = 1'b1;
        s0_v = 1'b1; s0_d = 8'h11; s0_l = 1'b0;
        s1_v = 1'b1; s1_d = 8'h22; s1_l = 1'b0;
        clr();

        // Reset state, with both sources requesting.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s0_tready", a_s0r, 0);
        chk("rst_s1_tready", a_s1r, 0);
        chk("rst_tx_tvalid", a_tv, 0);
        chk("rst_grant", a_g, 0);
        chk("rst_trunc_err", a_te, 0);
        chk("rst_frame_cnt0", a_fc0, 0);
        chk("rst_frame_cnt1", a_fc1, 0);
        @(posedge clk); #1;
        rst = 1'b0; s0_v = 1'b0; s1_v = 1'b0; s1_d = 8'h5A;
        repeat (2) @(posedge clk);

        // Cycle-by-cycle vectors: arbitration, passthrough, tready/tvalid gaps, tlast, gap entry.
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            s0_v = tbl[i].s0v; s0_d = tbl[i].s0d; s0_l = tbl[i].s0l;
            s1_v = tbl[i].s1v; txr = tbl[i].txr;
            @(negedge clk);
            chk($sformatf("tbl%0d", i),
                {18'd0, a_td, a_tv, a_tl, a_s0r, a_s1r, a_g},
                {18'd0, tbl[i].ed, tbl[i].ev, tbl[i].el, tbl[i].er0, tbl[i].er1, tbl[i].eg});
        end
        chk("tbl_frame_cnt0", a_fc0, 1);
        man = 1'b0;
        wait_cyc(20);

        // 20-byte s0 frame.
        clr();
        push_frame(0, 20, 8'h01);
        en0 = 1'b1;
        wait_last("t2", 1, 200);
        wait_cyc(15);
        chk("t2_nbeats", outq.size(), 20);
        chk_stream("t2_data");
        chk("t2_grant01_cycles", g01_cyc, 20);
        chk("t2_s1_tready_seen", s1r_seen, 0);
        chk("t2_frame_cnt0", a_fc0, 2);

        // Both sources continuously valid, 8-byte frames.
        clr();
        for (int f = 0; f < 9; f++) push_frame(0, 8, 8'(f * 16));
        for (int f = 0; f < 3; f++) push_frame(1, 8, 8'(8'hA0 + f * 8));
        en1 = 1'b1;
        wait_last("t3", 12, 1500);
        wait_cyc(5);
        newf = 1'b1;
        foreach (outq[i]) begin
            if (newf) begin fsrc.push_back(outq[i].g); ffirst.push_back(outq[i].cyc); end
            if (outq[i].l) flast.push_back(outq[i].cyc);
            newf = outq[i].l;
        end
        chk("t3_nframes", fsrc.size(), 12);
        for (int k = 0; k < 12 && k < fsrc.size(); k++)
            chk($sformatf("t3_src%0d", k), fsrc[k], exp_src[k]);
        for (int k = 1; k < 12 && k < ffirst.size() && k <= flast.size(); k++)
            chk($sformatf("t3_idle_gap%0d", k), ffirst[k] - flast[k-1] - 1, 12);
        chk_stream("t3_data");
        chk("t3_frame_cnt1", a_fc1, 3);

        // s1 64-byte frame under tready 1,0,0,1 with s0 arriving mid-frame.
        clr();
        push_frame(1, 64, 8'h40);
        tog = 1'b1;
        begin
            int k = 0;
            while (outq.size() < 10 && k < 200) begin wait_cyc(1); k++; end
        end
        push_frame(0, 4, 8'hC0);
        wait_last("t4", 2, 1000);
        tog = 1'b0;
        wait_cyc(5);
        chk("t4_nbeats", outq.size(), 68);
        bad = 0;
        for (int i = 0; i < 64 && i < outq.size(); i++) if (outq[i].g !== 2'b10) bad++;
        chk("t4_grant_held", bad, 0);
        if (outq.size() > 64) chk("t4_next_src", outq[64].g, 2'b01);
        chk("t4_tready_mirror", mirror_err, 0);
        chk_stream("t4_data");

        // Instance B (MAX_FRAME_LEN=16): 40-byte s1 frame is truncated and drained.
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        sel = 1'b1;
        wait_cyc(2);
        clr();
        push_frame(1, 40, 8'h01);
        wait_last("t5", 1, 200);
        begin
            int k = 0;
            while (q1.size() > 0 && k < 200) begin wait_cyc(1); k++; end
        end
        wait_cyc(20);
        chk("t5_nbeats", outq.size(), 16);
        bad = 0;
        foreach (outq[i]) if (outq[i].d !== 8'(i + 1) || outq[i].l !== (i == 15)) bad++;
        chk("t5_data", bad, 0);
        chk("t5_trunc_pulses", trunc_cnt, 1);
        if (outq.size() == 16) chk("t5_trunc_cycle", trunc_cyc, outq[15].cyc + 1);
        chk("t5_drain_cycles", drain_cyc, 24);
        chk("t5_src_consumed", q1.size(), 0);
        chk("t5_frame_cnt1", b_fc1, 1);

        // Instance B: exactly 16 bytes with natural tlast on byte 16.
        clr();
        push_frame(0, 16, 8'h90);
        wait_last("t6", 1, 200);
        wait_cyc(20);
        chk("t6_nbeats", outq.size(), 16);
        chk_stream("t6_data");
        chk("t6_trunc_pulses", trunc_cnt, 0);
        chk("t6_drain_cycles", drain_cyc, 0);
        chk("t6_frame_cnt0", b_fc0, 1);

        // Instance A: reset on beat 5 of a 30-byte s0 frame, then an s1 frame.
        sel = 1'b0;
        clr();
        push_frame(0, 30, 8'h20);
        begin
            int k = 0;
            while (outq.size() < 4 && k < 200) begin wait_cyc(1); k++; end
        end
        rst = 1'b1;
        @(negedge clk);
        chk("t7_inrst_tvalid", a_tv, 0);
        chk("t7_inrst_s0_tready", a_s0r, 0);
        wait_cyc(1);
        en0 = 1'b0;
        q0.delete();
        @(negedge clk);
        chk("t7_post_grant", a_g, 0);
        chk("t7_post_tvalid", a_tv, 0);
        chk("t7_post_treadys", {a_s0r, a_s1r}, 0);
        chk("t7_post_frame_cnt0", a_fc0, 0);
        chk("t7_post_frame_cnt1", a_fc1, 0);
        wait_cyc(1);
        rst = 1'b0;
        chk("t7_no_tlast", count_last(), 0);
        wait_cyc(2);
        clr();
        push_frame(1, 4, 8'hE0);
        wait_last("t7", 1, 100);
        wait_cyc(2);
        if (outq.size() > 0) chk("t7_grant_latency", outq[0].cyc - s1v_first, 1);
        chk_stream("t7_data");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_frame_arbiter.md
Name: eth_tx_frame_arbiter

Overview:
- Shares the single 8-bit AXI-Stream Ethernet TX port (MAC tx_axis) between two frame sources.
- Source 0 is command-decoder responses (ack/readback packets, high priority). Source 1 is radar/ADC data frames (bulk).
- Arbitrates per frame with a starvation guard, enforces an inter-frame gap, and truncates/drains over-length frames so a stuck source cannot wedge the MAC.
- Sits in the gtx_clk_bufg domain, between the command decoder / data packetizer and the TX MAC.

Parameters:
- MAX_CONSEC, 4: maximum consecutive source-0 grants while source 1 is pending. Range 1..255.
- IFG_CYCLES, 12: idle cycles forced after every output frame. 0 means no gap. Range 0..255.
- MAX_FRAME_LEN, 1514: maximum beats per output frame. Range 2..65535.

Ports:
- gtx_clk_bufg  in  1  clock, 125 MHz
- gtx_reset  in  1  synchronous reset, active-high
- s0_axis_tdata  in  8  source 0 (command response) data
- s0_axis_tvalid  in  1  source 0 valid
- s0_axis_tlast  in  1  source 0 end of frame
- s0_axis_tready  out  1  source 0 ready
- s1_axis_tdata  in  8  source 1 (data) data
- s1_axis_tvalid  in  1  source 1 valid
- s1_axis_tlast  in  1  source 1 end of frame
- s1_axis_tready  out  1  source 1 ready
- tx_axis_tdata  out  8  to MAC
- tx_axis_tvalid  out  1  to MAC
- tx_axis_tlast  out  1  to MAC
- tx_axis_tready  in  1  from MAC
- grant  out  2  one-hot current owner: bit0 = s0, bit1 = s1; 00 when none
- trunc_err  out  1  one-cycle pulse when a frame is truncated
- frame_cnt0  out  16  completed s0 output frames, wraps at 0xFFFF
- frame_cnt1  out  16  completed s1 output frames, wraps at 0xFFFF

Behaviour:
- Clocking and reset
  - Single clock domain.
  - gtx_reset has priority over all other logic.
  - On reset: state IDLE; grant=00; all counters=0; consecutive counter=0; trunc_err=0.
  - While in reset, all tready and tvalid outputs are 0.
  - A reset asserted mid-frame abandons the frame immediately; no tlast is emitted.
- States: IDLE, GNT0, GNT1, DRAIN, GAP.
- IDLE (registered arbitration decision)
  - If s0_tvalid and (!s1_tvalid or consec<MAX_CONSEC): go to GNT0. If s1_tvalid was high in that cycle, consec increments (saturates at 255).
  - Else if s1_tvalid: go to GNT1 and clear consec to 0.
  - Simultaneous requests with consec<MAX_CONSEC go to s0.
  - The first output beat is available on the cycle after the decision, so request-to-first-beat latency is 1 cycle.
- GNTi datapath (combinational passthrough, 0 latency)
  - tx_axis_tdata = si_tdata.
  - tx_axis_tvalid = si_tvalid.
  - tx_axis_tlast = si_tlast | force_last.
  - si_tready = tx_axis_tready. The other source's tready = 0.
  - grant is registered and one-hot for the whole frame. It never changes until the frame's final beat handshakes.
- Beat counter
  - 16 bits; increments on each tx handshake; cleared when a frame ends.
  - force_last = (beat_cnt == MAX_FRAME_LEN-1).
- End of frame
  - Handshake with si_tlast: frame_cnti increments and the block goes to GAP (or IDLE if IFG_CYCLES=0).
  - Handshake with force_last and !si_tlast: frame_cnti increments, trunc_err pulses next cycle, and the block goes to DRAIN.
  - A frame of exactly MAX_FRAME_LEN beats whose natural tlast lands on the last beat is not a truncation: no trunc_err, no DRAIN.
- DRAIN
  - si_tready = 1 for the truncated source; tx_axis_tvalid = 0; grant keeps its value.
  - Beats are discarded until an si handshake with tlast, then the block goes to GAP/IDLE.
- GAP
  - Counter loads IFG_CYCLES-1 and counts down; exits to IDLE when it reaches 0.
  - grant=00 and all tready=0 during GAP.
- Source tvalid low mid-frame
  - The grant is held and no bubble is inserted on output; tvalid simply follows.
- Frame counters wrap 0xFFFF to 0x0000 silently.

Test Plan:
- Single s0 frame of 20 bytes 0x01..0x14, tx_axis_tready=1:
  - tx output shows the same 20 bytes with tlast on 0x14.
  - grant=01 for 20 cycles, then 12 gap cycles.
  - frame_cnt0=1; s1_tready stays 0 throughout.
- s0 and s1 both continuously valid with 8-byte frames, MAX_CONSEC=4:
  - Output frame order is s0,s0,s0,s0,s1,s0,s0,s0,s0,s1.
  - Every frame is separated by exactly 12 idle cycles.
- tx_axis_tready toggles 1,0,0,1 during an s1 64-byte frame:
  - No data loss or duplication; s1_tready mirrors tx_axis_tready.
  - The grant never switches even though s0_tvalid asserts mid-frame.
- MAX_FRAME_LEN=16, s1 sends 40 bytes:
  - 16 bytes output with tlast forced on byte 16; trunc_err pulses once.
  - Remaining 24 bytes consumed with tx_axis_tvalid=0; then GAP.
  - frame_cnt1=1.
- MAX_FRAME_LEN=16, s0 sends exactly 16 bytes with tlast on byte 16:
  - Normal completion; trunc_err stays 0; no DRAIN.
- gtx_reset asserted on beat 5 of a 30-byte s0 frame:
  - Next cycle: grant=00, all tready/tvalid=0, counters=0.
  - After release, a new s1 frame is granted within 1 cycle of tvalid.
